// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM state encoding,
// coin values, default pricing and a helper that sums one cycle's coin pulses.
package vend_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCredit,
    StDispense,
    StChange
  } vend_state_e;

  localparam int unsigned NICKEL  = 1;
  localparam int unsigned DIME    = 2;
  localparam int unsigned QUARTER = 5;

  localparam int unsigned DEFAULT_PRICE      = 15;
  localparam int unsigned DEFAULT_MAX_CREDIT = 40;

  function automatic logic [3:0] coin_sum(input logic n, input logic d, input logic q);
    logic [3:0] s;
    s = '0;
    if (n) s = s + 4'(NICKEL);
    if (d) s = s + 4'(DIME);
    if (q) s = s + 4'(QUARTER);
    return s;
  endfunction

endpackage

// File: rtl/vend_controller_if.sv
// Button front-end / actuator / display bundle for vend_controller.
// master drives the pulses and sold-out levels, slave is the controller.
interface vend_controller_if #(
  parameter int unsigned NUM_ITEMS = 4,
  parameter int unsigned CREDIT_W  = 6
);
  localparam int unsigned ITEM_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  logic                 coin_n;
  logic                 coin_d;
  logic                 coin_q;
  logic [NUM_ITEMS-1:0] sel;
  logic                 cancel;
  logic [NUM_ITEMS-1:0] item_empty;
  logic [CREDIT_W-1:0]  credit;
  logic                 coin_reject;
  logic                 deny;
  logic                 dispense;
  logic [ITEM_W-1:0]    dispense_item;
  logic                 change_nickel;
  logic                 busy;

  modport master (
    output coin_n, coin_d, coin_q, sel, cancel, item_empty,
    input  credit, coin_reject, deny, dispense, dispense_item, change_nickel, busy
  );

  modport slave (
    input  coin_n, coin_d, coin_q, sel, cancel, item_empty,
    output credit, coin_reject, deny, dispense, dispense_item, change_nickel, busy
  );

endinterface

// File: rtl/change_dispenser.sv
// Returns a loaded nickel count as a 1-high/1-low pulse stream, decrementing
// the count on every pulse and flagging the last pulse via o_done.
module change_dispenser #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_pulse,
  output logic             o_done,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             r_active;
  logic             r_pulse;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count  <= '0;
      r_active <= 1'b0;
      r_pulse  <= 1'b0;
    end else if (i_load) begin
      r_count  <= i_load_val;
      r_active <= (i_load_val != '0);
      r_pulse  <= (i_load_val != '0);
    end else if (r_active) begin
      if (r_pulse) begin
        r_count <= r_count - CNT_W'(1);
        r_pulse <= 1'b0;
        if (r_count == CNT_W'(1)) r_active <= 1'b0;
      end else begin
        r_pulse <= 1'b1;
      end
    end
  end

  assign o_pulse = r_pulse;
  assign o_done  = r_active && r_pulse && (r_count == CNT_W'(1));
  assign o_count = r_count;

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: coin accumulation with a credit ceiling, priority-encoded
// item select, timed dispense and nickel-by-nickel change return.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned NUM_ITEMS   = 4,
  parameter int unsigned PRICE       = DEFAULT_PRICE,
  parameter int unsigned MAX_CREDIT  = DEFAULT_MAX_CREDIT,
  parameter int unsigned CREDIT_W    = 6,
  parameter int unsigned DISP_CYCLES = 8
) (
  input logic              i_clk,
  input logic              i_rst,
  vend_controller_if.slave io_bus
);

  localparam int unsigned ITEM_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam int unsigned DISP_W = $clog2(DISP_CYCLES + 1);

  vend_state_e         r_state, w_state_next;
  logic [CREDIT_W-1:0] r_credit, w_credit_next, w_credit_acc, w_chg_val, w_chg_count;
  logic [DISP_W-1:0]   r_disp_cnt, w_disp_next;
  logic [ITEM_W-1:0]   r_item, w_item_next, w_sel_idx;
  logic                r_coin_reject, w_coin_rej_next;
  logic                r_deny, w_deny_next;
  logic                w_any_coin, w_sel_any, w_fits, w_grant;
  logic                w_chg_load, w_chg_pulse, w_chg_done;
  logic [CREDIT_W:0]   w_total;
  logic [3:0]          w_coin_sum;

  assign w_any_coin   = io_bus.coin_n | io_bus.coin_d | io_bus.coin_q;
  assign w_coin_sum   = coin_sum(io_bus.coin_n, io_bus.coin_d, io_bus.coin_q);
  assign w_total      = {1'b0, r_credit} + (CREDIT_W + 1)'(w_coin_sum);
  assign w_fits       = (w_total <= (CREDIT_W + 1)'(MAX_CREDIT));
  assign w_credit_acc = w_fits ? w_total[CREDIT_W-1:0] : r_credit;

  // Lowest set select bit wins.
  always_comb begin
    w_sel_idx = '0;
    for (int i = int'(NUM_ITEMS) - 1; i >= 0; i--) begin
      if (io_bus.sel[i]) w_sel_idx = ITEM_W'(i);
    end
  end

  assign w_sel_any = |io_bus.sel;
  assign w_grant   = w_sel_any && (r_credit >= CREDIT_W'(PRICE))
                     && !io_bus.item_empty[w_sel_idx];

  always_comb begin
    w_state_next    = r_state;
    w_credit_next   = r_credit;
    w_disp_next     = r_disp_cnt;
    w_item_next     = r_item;
    w_coin_rej_next = 1'b0;
    w_deny_next     = 1'b0;
    w_chg_load      = 1'b0;
    w_chg_val       = r_credit;

    unique case (r_state)
      StIdle, StCredit: begin
        w_coin_rej_next = w_any_coin && !w_fits;
        w_credit_next   = w_credit_acc;
        w_state_next    = (w_credit_acc != '0) ? StCredit : StIdle;
        if (io_bus.cancel) begin
          // Coins of this cycle are already folded into the refund.
          if (w_credit_acc != '0) begin
            w_chg_load    = 1'b1;
            w_chg_val     = w_credit_acc;
            w_credit_next = '0;
            w_state_next  = StChange;
          end
        end else if (w_sel_any) begin
          if (w_grant) begin
            w_credit_next = w_credit_acc - CREDIT_W'(PRICE);
            w_item_next   = w_sel_idx;
            w_disp_next   = DISP_W'(DISP_CYCLES - 1);
            w_state_next  = StDispense;
          end else begin
            w_deny_next = 1'b1;
          end
        end
      end
      StDispense: begin
        w_coin_rej_next = w_any_coin;
        if (r_disp_cnt == '0) begin
          if (r_credit != '0) begin
            w_chg_load    = 1'b1;
            w_chg_val     = r_credit;
            w_credit_next = '0;
            w_state_next  = StChange;
          end else begin
            w_state_next = StIdle;
          end
        end else begin
          w_disp_next = r_disp_cnt - DISP_W'(1);
        end
      end
      StChange: begin
        w_coin_rej_next = w_any_coin;
        if (w_chg_done) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_credit      <= '0;
      r_disp_cnt    <= '0;
      r_item        <= '0;
      r_coin_reject <= 1'b0;
      r_deny        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_credit      <= w_credit_next;
      r_disp_cnt    <= w_disp_next;
      r_item        <= w_item_next;
      r_coin_reject <= w_coin_rej_next;
      r_deny        <= w_deny_next;
    end
  end

  change_dispenser #(
    .CNT_W (CREDIT_W)
  ) u_change (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_chg_load),
    .i_load_val (w_chg_val),
    .o_pulse    (w_chg_pulse),
    .o_done     (w_chg_done),
    .o_count    (w_chg_count)
  );

  // While returning change the dispenser holds the live credit count.
  assign io_bus.credit        = (r_state == StChange) ? w_chg_count : r_credit;
  assign io_bus.coin_reject   = r_coin_reject;
  assign io_bus.deny          = r_deny;
  assign io_bus.dispense      = (r_state == StDispense);
  assign io_bus.dispense_item = (r_state == StDispense) ? r_item : '0;
  assign io_bus.change_nickel = w_chg_pulse;
  assign io_bus.busy          = (r_state == StDispense) || (r_state == StChange);

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: stimulus tasks push expected output
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_vend_controller;

  localparam int unsigned NUM_ITEMS   = 4;
  localparam int unsigned CREDIT_W    = 6;
  localparam int unsigned DISP_CYCLES = 8;
  localparam int          PRICE       = 15;
  localparam int          MAX_CREDIT  = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vend_controller_if #(.NUM_ITEMS(NUM_ITEMS), .CREDIT_W(CREDIT_W)) io ();

  vend_controller #(
    .NUM_ITEMS   (NUM_ITEMS),
    .PRICE       (PRICE),
    .MAX_CREDIT  (MAX_CREDIT),
    .CREDIT_W    (CREDIT_W),
    .DISP_CYCLES (DISP_CYCLES)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (io)
  );

  int checks   = 0;
  int failures = 0;

  int q_reject[$];
  int q_deny[$];
  int q_disp[$];
  int q_nickel[$];

  int         m_credit = 0;
  logic [3:0] m_empty  = '0;
  assign io.item_empty = m_empty;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) return i;
    return -1;
  endfunction

  task automatic drive(input logic n, input logic d, input logic q,
                       input logic [3:0] s, input logic c);
    io.coin_n = n;
    io.coin_d = d;
    io.coin_q = q;
    io.sel    = s;
    io.cancel = c;
    @(posedge clk);
    #1;
    io.coin_n = 1'b0;
    io.coin_d = 1'b0;
    io.coin_q = 1'b0;
    io.sel    = '0;
    io.cancel = 1'b0;
  endtask

  // Model of one IDLE/CREDIT cycle; pushes the events the DUT must produce.
  task automatic apply(input logic n, input logic d, input logic q,
                       input logic [3:0] s, input logic c);
    int sum;
    int pre;
    int idx;
    sum = int'(n) * 1 + int'(d) * 2 + int'(q) * 5;
    pre = m_credit;
    if (m_credit + sum <= MAX_CREDIT) m_credit += sum;
    else q_reject.push_back(m_credit);
    if (c) begin
      for (int k = m_credit; k > 0; k--) q_nickel.push_back(k);
      m_credit = 0;
    end else if (s != 4'b0) begin
      idx = lowest(s);
      if (pre >= PRICE && !m_empty[idx]) begin
        q_disp.push_back(idx);
        m_credit -= PRICE;
        for (int k = m_credit; k > 0; k--) q_nickel.push_back(k);
        m_credit = 0;
      end else begin
        q_deny.push_back(m_credit);
      end
    end
    drive(n, d, q, s, c);
  endtask

  task automatic chk_credit(input string tag, input int exp);
    @(negedge clk);
    check(tag, int'(io.credit), exp);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (io.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", int'(io.busy), 0);
  endtask

  // Output monitor / scoreboard consumer.
  initial begin
    logic prev_disp;
    logic prev_nick;
    int   disp_len;
    prev_disp = 1'b0;
    prev_nick = 1'b0;
    disp_len  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_disp = 1'b0;
        prev_nick = 1'b0;
        disp_len  = 0;
      end else begin
        if (io.coin_reject) begin
          check("reject_expected", int'(q_reject.size() > 0), 1);
          if (q_reject.size() > 0) check("reject_credit", int'(io.credit), q_reject.pop_front());
        end
        if (io.deny) begin
          check("deny_expected", int'(q_deny.size() > 0), 1);
          if (q_deny.size() > 0) check("deny_credit", int'(io.credit), q_deny.pop_front());
        end
        if (io.dispense) begin
          if (!prev_disp) begin
            check("disp_expected", int'(q_disp.size() > 0), 1);
            if (q_disp.size() > 0) check("disp_item", int'(io.dispense_item), q_disp.pop_front());
          end
          disp_len++;
        end else if (prev_disp) begin
          check("disp_len", disp_len, DISP_CYCLES);
          disp_len = 0;
        end
        if (io.change_nickel) begin
          check("nickel_gap", int'(prev_nick), 0);
          check("nickel_expected", int'(q_nickel.size() > 0), 1);
          if (q_nickel.size() > 0) check("nickel_credit", int'(io.credit), q_nickel.pop_front());
        end
        prev_disp = io.dispense;
        prev_nick = io.change_nickel;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    io.coin_n = 1'b0;
    io.coin_d = 1'b0;
    io.coin_q = 1'b0;
    io.sel    = '0;
    io.cancel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_credit", int'(io.credit), 0);
    check("rst_busy", int'(io.busy), 0);
    check("rst_dispense", int'(io.dispense), 0);
    check("rst_nickel", int'(io.change_nickel), 0);
    rst = 1'b0;

    // Exact price, no change.
    repeat (3) apply(0, 0, 1, 4'b0000, 0);
    chk_credit("t2_credit15", 15);
    apply(0, 0, 0, 4'b0010, 0);
    wait_idle();
    chk_credit("t2_credit0", 0);

    // Overpay, multi-select, 7 nickels back.
    repeat (4) apply(0, 0, 1, 4'b0000, 0);
    apply(0, 1, 0, 4'b0000, 0);
    chk_credit("t3_credit22", 22);
    apply(0, 0, 0, 4'b0110, 0);
    wait_idle();
    chk_credit("t3_credit0", 0);

    // Ceiling: reject at 38+5, accept 37+3 = 40, reject at 40+1.
    repeat (7) apply(0, 0, 1, 4'b0000, 0);
    repeat (3) apply(1, 0, 0, 4'b0000, 0);
    chk_credit("t4_credit38", 38);
    apply(0, 0, 1, 4'b0000, 0);
    chk_credit("t4_credit38_kept", 38);
    apply(0, 0, 0, 4'b0000, 1);
    wait_idle();
    repeat (7) apply(0, 0, 1, 4'b0000, 0);
    apply(0, 1, 0, 4'b0000, 0);
    chk_credit("t4_credit37", 37);
    apply(1, 1, 0, 4'b0000, 0);
    chk_credit("t4_credit40", 40);
    apply(1, 0, 0, 4'b0000, 0);
    chk_credit("t4_credit40_kept", 40);
    apply(0, 0, 0, 4'b0000, 1);
    wait_idle();
    chk_credit("t4_credit0", 0);

    // Denials, then select+cancel refunds without deny.
    repeat (2) apply(0, 0, 1, 4'b0000, 0);
    apply(0, 0, 0, 4'b0001, 0);
    chk_credit("t5_credit10", 10);
    apply(0, 0, 1, 4'b0000, 0);
    m_empty = 4'b0100;
    apply(0, 0, 0, 4'b0100, 0);
    apply(0, 0, 0, 4'b1100, 0);
    chk_credit("t5_credit15", 15);
    apply(0, 0, 0, 4'b0001, 1);
    wait_idle();
    chk_credit("t5_credit0", 0);
    m_empty = 4'b0000;

    // Coins/select/cancel during dispense: coins rejected, rest ignored.
    repeat (4) apply(0, 0, 1, 4'b0000, 0);
    apply(0, 0, 0, 4'b0100, 0);
    drive(0, 0, 0, 4'b0000, 0);
    q_reject.push_back(5);
    drive(0, 0, 1, 4'b0000, 0);
    drive(0, 0, 0, 4'b0001, 0);
    q_reject.push_back(5);
    drive(1, 1, 0, 4'b0000, 0);
    drive(0, 0, 0, 4'b0000, 1);
    wait_idle();
    chk_credit("t6_credit0", 0);

    // Reset in the middle of returning change.
    apply(0, 0, 1, 4'b0000, 0);
    apply(0, 0, 0, 4'b0000, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t1_credit", int'(io.credit), 0);
    check("t1_busy", int'(io.busy), 0);
    check("t1_nickel", int'(io.change_nickel), 0);
    check("t1_dispense", int'(io.dispense), 0);
    check("t1_reject", int'(io.coin_reject), 0);
    check("t1_deny", int'(io.deny), 0);
    q_nickel.delete();
    m_credit = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t1_credit_after", int'(io.credit), 0);
    check("t1_busy_after", int'(io.busy), 0);

    check("sb_reject_left", q_reject.size(), 0);
    check("sb_deny_left", q_deny.size(), 0);
    check("sb_disp_left", q_disp.size(), 0);
    check("sb_nickel_left", q_nickel.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
